lfsr_stream_checker: RTL and testbench
======================================

# lfsr_stream_checker

Downstream consumer of the 4-bit LFSR pattern stage. It samples the LFSR word stream and self-synchronises to it by predicting each next word with the same recurrence, next = {q[2:0], q[1]^q[3]}. Once locked, it flags every mismatching word and keeps a saturating error count. It declares loss of lock after a run of consecutive misses. It is the pass/fail monitor for any link or FIFO placed between the generator and this block.

## Interface
Parameters:
- LOCK_CNT, 4: consecutive correct predictions required to enter LOCKED (range 1..15).
- LOSS_CNT, 3: consecutive mismatches in LOCKED that force return to SEARCH (range 1..15).
- CNT_W, 8: error counter width.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion clears all state immediately; release is taken on clk.
- data_i  input  4  LFSR word from the upstream stage.
- valid_i  input  1  data_i is a new sample this cycle. No back-pressure; every valid sample is consumed.
- clear_i  input  1  synchronous clear of err_cnt_o.
- locked_o  output  1  checker is in LOCKED.
- err_o  output  1  one-cycle pulse; the previous valid sample mismatched while LOCKED.
- err_cnt_o  output  CNT_W  saturating count of mismatches seen in LOCKED.
- zero_o  output  1  one-cycle pulse; the previous valid sample was 4'b0000 (illegal lock-up word).

## Operation
Internal state:
- state: SEARCH or LOCKED.
- exp: 4-bit expected word.
- seeded: exp holds a usable prediction.
- run: match run in SEARCH, miss run in LOCKED.

Reset values:
- state=SEARCH, seeded=0, run=0, exp=0.
- locked_o=0, err_o=0, err_cnt_o=0, zero_o=0.

Cycles with valid_i=0 change nothing except err_o and zero_o, which return to 0.

SEARCH, on a valid sample s:
- s==0: zero_o=1; seeded=0; run=0. A zero word never seeds, because it would stay zero forever.
- seeded=0 and s!=0: exp=next(s); seeded=1; run=0. The first sample only seeds.
- seeded=1 and s==exp: run+1.
  - If run+1==LOCK_CNT: state=LOCKED, run=0, exp=next(exp).
  - Otherwise: exp=next(s).
- seeded=1 and s!=exp (s!=0): run=0; exp=next(s), which reseeds from the received word.
- err_o and err_cnt_o never change in SEARCH.

LOCKED, on a valid sample s:
- exp always advances from itself, exp=next(exp), never from s. A single corrupted word therefore does not derail the prediction.
- s==exp: run=0.
- s!=exp: err_o=1; err_cnt_o+1, saturating at all-ones; run+1. A zero sample is also a mismatch and also pulses zero_o.
- If run+1==LOSS_CNT: state=SEARCH, seeded=0, run=0. The next valid sample reseeds.

clear_i:
- err_cnt_o=0 on the next edge.
- If it coincides with a counted mismatch, clear wins: the count becomes 0, and err_o still pulses.

locked_o is a direct decode of the registered state.

## Timing
- All outputs are registered. A sample presented with valid_i at edge N is reflected in err_o, zero_o and err_cnt_o after edge N.
- locked_o rises after the edge that accepts the LOCK_CNT-th consecutive correct prediction. With back-to-back valid samples from a clean stream, that is LOCK_CNT+1 valid samples after the first one (seed plus LOCK_CNT matches).
- locked_o falls after the edge that accepts the LOSS_CNT-th consecutive mismatch. err_o still pulses for that sample.
- valid_i gaps of any length are transparent: the prediction holds across idle cycles.
- Reset asserted mid-operation clears everything at once, including an in-flight err_o pulse. After release the checker relocks from scratch.
- err_cnt_o at all-ones stays at all-ones on further errors; err_o still pulses.

## Test plan
- Clean stream, back-to-back valid: 1110,1100,1001,0011,0111,1111, repeating. Required: locked_o=1 after the 5th sample's edge (LOCK_CNT=4); no err_o; err_cnt_o=0 over 60 samples.
- Single error while LOCKED: replace one 1001 with 1011. Required: err_o pulses once; err_cnt_o=1; locked_o stays 1; the next sample (0011) matches.
- Loss of lock: three consecutive corrupted words while LOCKED. Required: three err_o pulses; err_cnt_o=3; locked_o=0 after the third. A clean stream then relocks after 5 further samples.
- Zero word: a 0000 sample in SEARCH gives zero_o=1, no seeding, and no lock until a nonzero seed plus 4 matches. A 0000 sample in LOCKED gives zero_o=1, err_o=1 and err_cnt_o+1.
- Saturation and clear (CNT_W=2): five mismatches give err_cnt_o=3. clear_i on the same cycle as a further mismatch gives err_cnt_o=0 with err_o=1.
- Async reset and valid gaps: insert random valid_i=0 gaps in a clean stream; required: lock and no errors. Drop reset low between edges while LOCKED; required: locked_o=0 and err_cnt_o=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for the 4-bit LFSR word stream.
// Seeds from a received word, locks after a run of correct predictions, then counts mismatches.
module lfsr_stream_checker #(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       data_i,
   input  logic             valid_i,
   input  logic             clear_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic             zero_o
);

   typedef enum logic {SEARCH, LOCKED} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

   function automatic logic [3:0] next_word(input logic [3:0] q);
      return {q[2:0], q[1] ^ q[3]};
   endfunction

   state_t     state;
   logic [3:0] exp_word;
   logic       seeded;
   logic [3:0] run;
   logic [3:0] run_inc;
   logic       hit;
   logic       is_zero;

   assign run_inc  = run + 4'd1;
   assign hit      = (data_i == exp_word);
   assign is_zero  = (data_i == 4'b0000);
   assign locked_o = (state == LOCKED);

   // run counts matches while searching and misses while locked; once locked the
   // prediction free-runs from itself so a corrupted word cannot derail it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= SEARCH;
         exp_word  <= 4'b0000;
         seeded    <= 1'b0;
         run       <= 4'd0;
         err_o     <= 1'b0;
         zero_o    <= 1'b0;
         err_cnt_o <= '0;
      end else begin
         err_o  <= 1'b0;
         zero_o <= 1'b0;
         if (valid_i) begin
            if (is_zero) zero_o <= 1'b1;
            case (state)
               SEARCH: begin
                  if (is_zero) begin
                     seeded <= 1'b0;
                     run    <= 4'd0;
                  end else if (!seeded) begin
                     exp_word <= next_word(data_i);
                     seeded   <= 1'b1;
                     run      <= 4'd0;
                  end else if (hit) begin
                     exp_word <= next_word(data_i);
                     if (run_inc == LOCK_N) begin
                        state <= LOCKED;
                        run   <= 4'd0;
                     end else begin
                        run <= run_inc;
                     end
                  end else begin
                     exp_word <= next_word(data_i);
                     run      <= 4'd0;
                  end
               end
               LOCKED: begin
                  exp_word <= next_word(exp_word);
                  if (hit) begin
                     run <= 4'd0;
                  end else begin
                     err_o <= 1'b1;
                     if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                     if (run_inc == LOSS_N) begin
                        state  <= SEARCH;
                        seeded <= 1'b0;
                        run    <= 4'd0;
                     end else begin
                        run <= run_inc;
                     end
                  end
               end
               default: state <= SEARCH;
            endcase
         end
         // A clear coinciding with a counted miss still leaves the count at zero.
         if (clear_i) err_cnt_o <= '0;
      end
   end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker; a second instance with a 2-bit counter covers saturation.
module tb_lfsr_stream_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] data_i = 4'b0000;
   logic       valid_i = 1'b0;
   logic       clear_i = 1'b0;

   logic       locked_o, err_o, zero_o;
   logic [7:0] err_cnt_o;
   logic       s_locked_o, s_err_o, s_zero_o;
   logic [1:0] s_err_cnt_o;

   int tests_run = 0;
   int tests_failed = 0;
   int ph = 0;
   logic [3:0] seq [6] = '{4'hE, 4'hC, 4'h9, 4'h3, 4'h7, 4'hF};

   always #5 clk = ~clk;

   lfsr_stream_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .clear_i(clear_i),
      .locked_o(locked_o), .err_o(err_o), .err_cnt_o(err_cnt_o), .zero_o(zero_o)
   );

   lfsr_stream_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .clear_i(clear_i),
      .locked_o(s_locked_o), .err_o(s_err_o), .err_cnt_o(s_err_cnt_o), .zero_o(s_zero_o)
   );

   // Inputs change 1 time unit after the rising edge, so outputs are read there too.
   task automatic send(input logic [3:0] s);
      data_i  = s;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic send_clean();
      send(seq[ph]);
      ph = (ph + 1) % 6;
   endtask

   task automatic send_bad(input logic [3:0] flip);
      send(seq[ph] ^ flip);
      ph = (ph + 1) % 6;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      tests_run++;
      if ({locked_o, err_o, zero_o, err_cnt_o} !== 11'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state got %b want 0", {locked_o, err_o, zero_o, err_cnt_o});
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_clean_lock();
      int bad = 0;
      ph = 0;
      for (int i = 0; i < 60; i++) begin
         send_clean();
         if (err_o !== 1'b0 || zero_o !== 1'b0) bad++;
         if (i == 3) begin
            tests_run++;
            if (locked_o !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL clean_early_lock locked_o got %b want 0", locked_o);
            end
         end
         if (i == 4) begin
            tests_run++;
            if (locked_o !== 1'b1) begin
               tests_failed++;
               $display("[TB] FAIL clean_lock locked_o got %b want 1", locked_o);
            end
         end
      end
      tests_run++;
      if (bad !== 0 || err_cnt_o !== 8'd0 || locked_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL clean_stream pulses=%0d cnt=%0d locked=%b want 0,0,1", bad, err_cnt_o, locked_o);
      end
   endtask

   task automatic test_single_error();
      send(4'hE);
      send(4'hC);
      send(4'hB);
      ph = 3;
      tests_run++;
      if (err_o !== 1'b1 || err_cnt_o !== 8'd1 || locked_o !== 1'b1 || s_err_cnt_o !== 2'd1) begin
         tests_failed++;
         $display("[TB] FAIL single_error err=%b cnt=%0d locked=%b scnt=%0d want 1,1,1,1", err_o, err_cnt_o, locked_o, s_err_cnt_o);
      end
      send_clean();
      tests_run++;
      if (err_o !== 1'b0 || err_cnt_o !== 8'd1 || locked_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL after_single_error err=%b cnt=%0d locked=%b want 0,1,1", err_o, err_cnt_o, locked_o);
      end
   endtask

   task automatic test_loss_of_lock();
      clear_i = 1'b1;
      idle(1);
      clear_i = 1'b0;
      tests_run++;
      if (err_cnt_o !== 8'd0 || s_err_cnt_o !== 2'd0) begin
         tests_failed++;
         $display("[TB] FAIL idle_clear cnt=%0d scnt=%0d want 0,0", err_cnt_o, s_err_cnt_o);
      end
      for (int k = 0; k < 3; k++) begin
         send_bad(4'h1);
         tests_run++;
         if (err_o !== 1'b1 || err_cnt_o !== 8'(k + 1) || locked_o !== (k < 2)) begin
            tests_failed++;
            $display("[TB] FAIL loss_miss%0d err=%b cnt=%0d locked=%b want 1,%0d,%b", k, err_o, err_cnt_o, locked_o, k + 1, k < 2);
         end
      end
      for (int k = 0; k < 5; k++) begin
         send_clean();
         if (k >= 3) begin
            tests_run++;
            if (locked_o !== (k == 4) || err_o !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL relock%0d locked=%b err=%b want %b,0", k, locked_o, err_o, k == 4);
            end
         end
      end
   endtask

   task automatic test_zero_word();
      send(4'h0);
      ph = (ph + 1) % 6;
      tests_run++;
      if (zero_o !== 1'b1 || err_o !== 1'b1 || err_cnt_o !== 8'd4 || s_err_cnt_o !== 2'd3 || locked_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL zero_locked zero=%b err=%b cnt=%0d scnt=%0d locked=%b want 1,1,4,3,1", zero_o, err_o, err_cnt_o, s_err_cnt_o, locked_o);
      end
      send_clean();
      tests_run++;
      if (zero_o !== 1'b0 || err_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL zero_pulse_len zero=%b err=%b want 0,0", zero_o, err_o);
      end
      pulse_reset();
      send(4'hE);
      send(4'hC);
      send(4'h0);
      tests_run++;
      if (zero_o !== 1'b1 || err_o !== 1'b0 || locked_o !== 1'b0 || err_cnt_o !== 8'd0) begin
         tests_failed++;
         $display("[TB] FAIL zero_search zero=%b err=%b locked=%b cnt=%0d want 1,0,0,0", zero_o, err_o, locked_o, err_cnt_o);
      end
      ph = 2;
      for (int k = 0; k < 5; k++) begin
         send_clean();
         if (k >= 3) begin
            tests_run++;
            if (locked_o !== (k == 4)) begin
               tests_failed++;
               $display("[TB] FAIL zero_reseed%0d locked=%b want %b", k, locked_o, k == 4);
            end
         end
      end
   endtask

   task automatic test_saturation_and_clear();
      send_bad(4'h8);
      send_bad(4'h8);
      send_clean();
      send_bad(4'h8);
      tests_run++;
      if (s_err_cnt_o !== 2'd3 || err_cnt_o !== 8'd3) begin
         tests_failed++;
         $display("[TB] FAIL sat_three scnt=%0d cnt=%0d want 3,3", s_err_cnt_o, err_cnt_o);
      end
      send_bad(4'h8);
      send_clean();
      tests_run++;
      if (s_err_cnt_o !== 2'd3 || err_cnt_o !== 8'd4 || s_locked_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL sat_hold scnt=%0d cnt=%0d locked=%b want 3,4,1", s_err_cnt_o, err_cnt_o, s_locked_o);
      end
      send_bad(4'h8);
      tests_run++;
      if (s_err_o !== 1'b1 || s_err_cnt_o !== 2'd3) begin
         tests_failed++;
         $display("[TB] FAIL sat_pulse err=%b scnt=%0d want 1,3", s_err_o, s_err_cnt_o);
      end
      clear_i = 1'b1;
      send_bad(4'h8);
      clear_i = 1'b0;
      tests_run++;
      if (err_o !== 1'b1 || err_cnt_o !== 8'd0 || s_err_cnt_o !== 2'd0) begin
         tests_failed++;
         $display("[TB] FAIL clear_wins err=%b cnt=%0d scnt=%0d want 1,0,0", err_o, err_cnt_o, s_err_cnt_o);
      end
      send_clean();
   endtask

   task automatic test_gaps_and_async_reset();
      int bad = 0;
      send_bad(4'h1);
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if (locked_o !== 1'b0 || err_cnt_o !== 8'd0 || err_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset locked=%b cnt=%0d err=%b want 0,0,0", locked_o, err_cnt_o, err_o);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      ph = 0;
      for (int i = 0; i < 30; i++) begin
         send_clean();
         if (err_o !== 1'b0 || zero_o !== 1'b0) bad++;
         if (i == 3 || i == 4) begin
            tests_run++;
            if (locked_o !== (i == 4)) begin
               tests_failed++;
               $display("[TB] FAIL gap_lock%0d locked=%b want %b", i, locked_o, i == 4);
            end
         end
         idle($urandom_range(0, 3));
      end
      tests_run++;
      if (bad !== 0 || err_cnt_o !== 8'd0 || locked_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL gap_stream pulses=%0d cnt=%0d locked=%b want 0,0,1", bad, err_cnt_o, locked_o);
      end
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_single_error();
      test_loss_of_lock();
      test_zero_word();
      test_saturation_and_clear();
      test_gaps_and_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
